// File: rtl/mac_pkg.sv
// Shared types for the float16 systolic array MAC lanes.
// Operand pairs are packed {B, A} with A in the low half.
package mac_pkg;

  localparam int FP16_W = 16;

  typedef logic [1:0][FP16_W-1:0] fp16_pair_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } feeder_state_t;

endpackage

// File: rtl/mac_operand_feeder_if.sv
// Operand stream (valid/ready) and MAC input bus (DVI/DI/RELEASE) bundles.
interface mac_operand_feeder_if;
  import mac_pkg::*;

  logic       valid;
  logic       ready;
  fp16_pair_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// The MAC consumes one pair per DVI; rls marks the last pair of a dot product.
interface mac_operand_bus_if;
  import mac_pkg::*;

  logic       dvi;
  fp16_pair_t di;
  logic       rls;

  modport master (output dvi, output di, output rls);
  modport slave  (input dvi, input di, input rls);
endinterface

// File: rtl/mac_operand_fifo.sv
// Small synchronous operand FIFO with flush; no push-to-pop bypass.
module mac_operand_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  fp16_pair_t push_data,
  input  logic       pop,
  output fp16_pair_t head,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  fp16_pair_t       mem_q [DEPTH];
  fp16_pair_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Operand feeder for one MAC lane: buffers a pair stream and issues one
// pair per cycle, marking the last pair of each dot product with RELEASE.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int   FIFO_DEPTH       = 4,
  parameter int   LEN_W            = 16,
  parameter logic CNT_RELEASE_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [LEN_W-1:0] cfg_num,
  input  logic             hold,
  mac_operand_feeder_if.slave  s_if,
  mac_operand_bus_if.master    m_if,
  output logic             busy,
  output logic             done,
  output logic             err_len
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  feeder_state_t    state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] elem_cnt_q, elem_cnt_d;
  logic [LEN_W-1:0] vec_cnt_q, vec_cnt_d;
  logic             dvi_q, dvi_d;
  fp16_pair_t       di_q, di_d;
  logic             rls_q, rls_d;
  logic             done_q, done_d;
  logic             err_len_q, err_len_d;

  fp16_pair_t fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       issue;

  assign issue = (state_q == RUN) & ~fifo_empty & ~hold;

  mac_operand_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clr),
    .push      (s_if.valid),
    .push_data (s_if.data),
    .pop       (issue),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Job control: a flush wins over start and issue alike.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    elem_cnt_d = elem_cnt_q;
    vec_cnt_d  = vec_cnt_q;
    dvi_d      = 1'b0;
    di_d       = di_q;
    rls_d      = 1'b0;
    done_d     = 1'b0;
    err_len_d  = 1'b0;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if ((cfg_len != '0) && (cfg_num != '0)) begin
              state_d    = RUN;
              len_d      = cfg_len;
              elem_cnt_d = cfg_len;
              vec_cnt_d  = cfg_num;
            end else begin
              err_len_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            dvi_d = 1'b1;
            di_d  = fifo_head;
            rls_d = (elem_cnt_q == ONE) & ~CNT_RELEASE_MODE;
            if (elem_cnt_q == ONE) begin
              elem_cnt_d = len_q;
              vec_cnt_d  = vec_cnt_q - ONE;
              if (vec_cnt_q == ONE) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              elem_cnt_d = elem_cnt_q - ONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      elem_cnt_q <= '0;
      vec_cnt_q  <= '0;
      dvi_q      <= 1'b0;
      di_q       <= '0;
      rls_q      <= 1'b0;
      done_q     <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      elem_cnt_q <= elem_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
      dvi_q      <= dvi_d;
      di_q       <= di_d;
      rls_q      <= rls_d;
      done_q     <= done_d;
      err_len_q  <= err_len_d;
    end
  end

  assign s_if.ready = ~fifo_full;
  assign m_if.dvi   = dvi_q;
  assign m_if.di    = di_q;
  assign m_if.rls   = rls_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign err_len    = err_len_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder; a second instance runs with
// count-based release so RELEASE must stay low there.
module tb_mac_operand_feeder;
  import mac_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        start;
  logic [15:0] cfg_len;
  logic [15:0] cfg_num;
  logic        hold;
  logic        s_valid;
  fp16_pair_t  s_data;
  logic        busy0, done0, err0;
  logic        busy1, done1, err1;
  int          n_checks;
  int          n_pass;

  mac_operand_feeder_if s_if0 ();
  mac_operand_feeder_if s_if1 ();
  mac_operand_bus_if    m_if0 ();
  mac_operand_bus_if    m_if1 ();

  assign s_if0.valid = s_valid;
  assign s_if0.data  = s_data;
  assign s_if1.valid = s_valid;
  assign s_if1.data  = s_data;

  mac_operand_feeder #(
    .FIFO_DEPTH (4), .LEN_W (16), .CNT_RELEASE_MODE (1'b0)
  ) dut0 (
    .clk (clk), .rst_n (rst_n), .clr (clr), .start (start),
    .cfg_len (cfg_len), .cfg_num (cfg_num), .hold (hold),
    .s_if (s_if0.slave), .m_if (m_if0.master),
    .busy (busy0), .done (done0), .err_len (err0)
  );

  mac_operand_feeder #(
    .FIFO_DEPTH (4), .LEN_W (16), .CNT_RELEASE_MODE (1'b1)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .clr (clr), .start (start),
    .cfg_len (cfg_len), .cfg_num (cfg_num), .hold (hold),
    .s_if (s_if1.slave), .m_if (m_if1.master),
    .busy (busy1), .done (done1), .err_len (err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fp16_pair_t pair(input int i);
    fp16_pair_t p;
    p[1] = 16'h4000;
    p[0] = 16'h3C00 + i[15:0];
    return p;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input fp16_pair_t d);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
  endtask

  task automatic start_job(input logic [15:0] len, input logic [15:0] num);
    cfg_len = len;
    cfg_num = num;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic expect_bus(input string tag, input bit e_dvi, input fp16_pair_t e_di,
                            input bit e_rel, input bit e_done, input bit e_busy);
    check_output({tag, ".dvi"}, 32'(m_if0.dvi), 32'(e_dvi));
    if (e_dvi) check_output({tag, ".di"}, m_if0.di, e_di);
    check_output({tag, ".rel"}, 32'(m_if0.rls), 32'(e_rel));
    check_output({tag, ".done"}, 32'(done0), 32'(e_done));
    check_output({tag, ".busy"}, 32'(busy0), 32'(e_busy));
  endtask

  task automatic run_stream(input bit with_hold, input int base);
    int idx;
    start_job(16'd3, 16'd2);
    for (int k = 1; k <= 10; k++) begin
      s_valid = (k <= 6);
      s_data  = pair(base + k - 1);
      hold    = with_hold && (k == 4 || k == 5);
      step();
      s_valid = 1'b0;
      hold    = 1'b0;
      if (!with_hold) idx = (k >= 2 && k <= 7) ? k - 1 : 0;
      else            idx = (k == 2 || k == 3) ? k - 1 : ((k >= 6 && k <= 9) ? k - 3 : 0);
      if (idx != 0)
        expect_bus($sformatf("stream%0d.k%0d", with_hold, k), 1'b1, pair(base + idx - 1),
                   (idx == 3 || idx == 6), (idx == 6), (idx != 6));
      else
        expect_bus($sformatf("stream%0d.k%0d", with_hold, k), 1'b0, '0, 1'b0, 1'b0,
                   with_hold ? (k < 9) : (k < 7));
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b1;
    clr      = 1'b0;
    start    = 1'b0;
    cfg_len  = '0;
    cfg_num  = '0;
    hold     = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    #1 rst_n = 1'b0;
    #11;
    check_output("rst.dvi", 32'(m_if0.dvi), 0);
    check_output("rst.di", m_if0.di, 0);
    check_output("rst.rel", 32'(m_if0.rls), 0);
    check_output("rst.busy", 32'(busy0), 0);
    check_output("rst.done", 32'(done0), 0);
    check_output("rst.err", 32'(err0), 0);
    check_output("rst.ready", 32'(s_if0.ready), 1);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Prefilled single dot product of four pairs.
    for (int i = 0; i < 4; i++) apply_stimulus(pair(i));
    check_output("pre.ready", 32'(s_if0.ready), 0);
    start_job(16'd4, 16'd1);
    expect_bus("pre.start", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_bus($sformatf("pre.p%0d", i), 1'b1, pair(i), (i == 3), (i == 3), (i != 3));
    end
    step();
    expect_bus("pre.after", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_output("pre.di_hold", m_if0.di, pair(3));

    // Streamed job, then the same job with a two-cycle stall.
    run_stream(1'b0, 16);
    run_stream(1'b1, 32);

    // Full FIFO: a pop cannot admit a push in the same cycle.
    for (int i = 0; i < 3; i++) apply_stimulus(pair(48 + i));
    check_output("full.ready3", 32'(s_if0.ready), 1);
    apply_stimulus(pair(51));
    check_output("full.ready4", 32'(s_if0.ready), 0);
    start_job(16'd1, 16'd1);
    check_output("full.ready_run", 32'(s_if0.ready), 0);
    s_valid = 1'b1;
    s_data  = pair(52);
    step();
    expect_bus("full.pop", 1'b1, pair(48), 1'b1, 1'b1, 1'b0);
    check_output("full.ready_pop", 32'(s_if0.ready), 1);
    step();
    s_valid = 1'b0;
    check_output("full.ready_refill", 32'(s_if0.ready), 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_output("full.clr_ready", 32'(s_if0.ready), 1);
    expect_bus("full.clr", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Zero-length configurations.
    start_job(16'd0, 16'd3);
    check_output("err.len0", 32'(err0), 1);
    check_output("err.len0_busy", 32'(busy0), 0);
    step();
    check_output("err.pulse", 32'(err0), 0);
    start_job(16'd2, 16'd0);
    check_output("err.num0", 32'(err0), 1);
    check_output("err.num0_busy", 32'(busy0), 0);

    // Flush two pairs into a five-pair dot product.
    for (int i = 0; i < 4; i++) apply_stimulus(pair(64 + i));
    start_job(16'd5, 16'd1);
    step();
    expect_bus("clr.p0", 1'b1, pair(64), 1'b0, 1'b0, 1'b1);
    step();
    expect_bus("clr.p1", 1'b1, pair(65), 1'b0, 1'b0, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    expect_bus("clr.next", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_output("clr.ready", 32'(s_if0.ready), 1);
    start_job(16'd1, 16'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_bus($sformatf("clr.empty%0d", i), 1'b0, '0, 1'b0, 1'b0, 1'b1);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;

    // Count-release instance: RELEASE stays low, DONE still on the last pair.
    for (int i = 0; i < 4; i++) apply_stimulus(pair(80 + i));
    start_job(16'd2, 16'd2);
    for (int i = 0; i < 4; i++) begin
      step();
      check_output($sformatf("cnt.p%0d.dvi", i), 32'(m_if1.dvi), 1);
      check_output($sformatf("cnt.p%0d.di", i), m_if1.di, pair(80 + i));
      check_output($sformatf("cnt.p%0d.rel", i), 32'(m_if1.rls), 0);
      check_output($sformatf("cnt.p%0d.done", i), 32'(done1), 32'(i == 3));
      check_output($sformatf("cnt.p%0d.rel0", i), 32'(m_if0.rls), 32'(i == 1 || i == 3));
    end

    // Asynchronous reset in the middle of a job.
    for (int i = 0; i < 2; i++) apply_stimulus(pair(96 + i));
    start_job(16'd4, 16'd1);
    step();
    expect_bus("arst.p0", 1'b1, pair(96), 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_output("arst.dvi", 32'(m_if0.dvi), 0);
    check_output("arst.di", m_if0.di, 0);
    check_output("arst.busy", 32'(busy0), 0);
    check_output("arst.ready", 32'(s_if0.ready), 1);
    @(negedge clk) rst_n = 1'b1;
    step();
    expect_bus("arst.after", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
